// File: rtl/ccd_phase_generator.sv
// ccd_phase_generator: CCD parallel/serial clock phase sequencer.
// Optional reset-gate output o_phi_rg when CCD_PHASE_RG_EN is defined.
module ccd_phase_generator #(
  parameter int N_PIXELS  = 16,
  parameter int N_LINES   = 8,
  parameter int HALF_PER  = 2,
  parameter int PHI_P_LEN = 3,
  parameter int PIX_W     = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1,
  parameter int LIN_W     = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_continuous,
  input  logic             i_abort,
  output logic             o_phi_p,
  output logic             o_phi_l1,
  output logic             o_phi_l2,
  output logic             o_enable,
  output logic [PIX_W-1:0] o_pixel_cnt,
  output logic [LIN_W-1:0] o_line_cnt,
  output logic             o_busy,
`ifdef CCD_PHASE_RG_EN
  output logic             o_phi_rg,
`endif
  output logic             o_frame_done
);

  localparam int PIX_T = 2 * HALF_PER;
  localparam int TMAX  = (PHI_P_LEN > PIX_T) ? PHI_P_LEN : PIX_T;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    T_PXF  = TW'(PHI_P_LEN - 1);
  localparam logic [TW-1:0]    T_SET  = TW'(HALF_PER - 1);
  localparam logic [TW-1:0]    T_PIX  = TW'(PIX_T - 1);
  localparam logic [TW-1:0]    T_HALF = TW'(HALF_PER);
  localparam logic [PIX_W-1:0] P_LAST = PIX_W'(N_PIXELS - 1);
  localparam logic [LIN_W-1:0] L_LAST = LIN_W'(N_LINES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PXFER,
    SETTLE,
    SERIAL,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [LIN_W-1:0] line_q, line_d;

  logic phi_p_q, phi_p_d;
  logic l1_q, l1_d;
  logic en_q, en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
`ifdef CCD_PHASE_RG_EN
  logic rg_q, rg_d;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      phi_p_q <= 1'b0;
      l1_q    <= 1'b1;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CCD_PHASE_RG_EN
      rg_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      phi_p_q <= phi_p_d;
      l1_q    <= l1_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CCD_PHASE_RG_EN
      rg_q    <= rg_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    pix_d   = pix_q;
    line_d  = line_q;
    if (i_abort) begin
      state_d = IDLE;
      tcnt_d  = '0;
      pix_d   = '0;
      line_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d = PXFER;
            tcnt_d  = '0;
          end
        end
        PXFER: begin
          if (tcnt_q == T_PXF) begin
            state_d = SETTLE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (tcnt_q == T_SET) begin
            state_d = SERIAL;
            tcnt_d  = '0;
            pix_d   = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        SERIAL: begin
          if (tcnt_q != T_PIX) begin
            tcnt_d = tcnt_q + 1'b1;
          end else begin
            tcnt_d = '0;
            if (pix_q != P_LAST) begin
              pix_d = pix_q + 1'b1;
            end else begin
              pix_d = '0;
              if (line_q == L_LAST) begin
                state_d = DONE;
                line_d  = '0;
              end else begin
                state_d = PXFER;
                line_d  = line_q + 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_d = i_continuous ? PXFER : IDLE;
          tcnt_d  = '0;
          pix_d   = '0;
          line_d  = '0;
        end
        default: begin
          state_d = IDLE;
          tcnt_d  = '0;
          pix_d   = '0;
          line_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    phi_p_d = (state_d == PXFER);
    en_d    = (state_d == SERIAL);
    l1_d    = !(en_d && (tcnt_d < T_HALF));
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
`ifdef CCD_PHASE_RG_EN
    rg_d    = en_d && (tcnt_d == T_HALF);
`endif
  end

  assign o_phi_p      = phi_p_q;
  assign o_phi_l1     = l1_q;
  assign o_phi_l2     = ~l1_q;
  assign o_enable     = en_q;
  assign o_pixel_cnt  = pix_q;
  assign o_line_cnt   = line_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
`ifdef CCD_PHASE_RG_EN
  assign o_phi_rg     = rg_q;
`endif

endmodule

// File: tb/tb_ccd_phase_generator.sv
// tb_ccd_phase_generator: random + directed check of ccd_phase_generator
// against a position-in-frame arithmetic reference model.
module tb_ccd_phase_generator;

  localparam int NP = 16;
  localparam int NL = 8;
  localparam int H  = 2;
  localparam int P  = 3;
  localparam int LINE  = P + H + 2 * H * NP;
  localparam int FRAME = NL * LINE + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic       abort;
  logic       phi_p;
  logic       phi_l1;
  logic       phi_l2;
  logic       en;
  logic [3:0] pix;
  logic [2:0] line;
  logic       busy;
  logic       fdone;
`ifdef CCD_PHASE_RG_EN
  logic       phi_rg;
`endif

  int n_chk;
  int n_fail;
  bit m_act;
  int m_pos;

  ccd_phase_generator #(
    .N_PIXELS(NP),
    .N_LINES(NL),
    .HALF_PER(H),
    .PHI_P_LEN(P)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_continuous(cont),
    .i_abort(abort),
    .o_phi_p(phi_p),
    .o_phi_l1(phi_l1),
    .o_phi_l2(phi_l2),
    .o_enable(en),
    .o_pixel_cnt(pix),
    .o_line_cnt(line),
    .o_busy(busy),
`ifdef CCD_PHASE_RG_EN
    .o_phi_rg(phi_rg),
`endif
    .o_frame_done(fdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp();
    int e_pp, e_l1, e_en, e_pix, e_line, e_busy, e_done, e_rg;
    int off, s;
    e_pp = 0; e_l1 = 1; e_en = 0; e_pix = 0; e_line = 0; e_rg = 0;
    e_busy = m_act ? 1 : 0;
    e_done = (m_act && m_pos == FRAME - 1) ? 1 : 0;
    if (m_act && m_pos < NL * LINE) begin
      e_line = m_pos / LINE;
      off = m_pos % LINE;
      if (off < P) begin
        e_pp = 1;
      end else if (off >= P + H) begin
        s = off - P - H;
        e_en = 1;
        e_pix = s / (2 * H);
        e_l1 = ((s % (2 * H)) >= H) ? 1 : 0;
        e_rg = ((s % (2 * H)) == H) ? 1 : 0;
      end
    end
    check("phi_p", int'(phi_p), e_pp);
    check("phi_l1", int'(phi_l1), e_l1);
    check("phi_l2", int'(phi_l2), 1 - e_l1);
    check("enable", int'(en), e_en);
    check("pixel_cnt", int'(pix), e_pix);
    check("line_cnt", int'(line), e_line);
    check("busy", int'(busy), e_busy);
    check("frame_done", int'(fdone), e_done);
`ifdef CCD_PHASE_RG_EN
    check("phi_rg", int'(phi_rg), e_rg);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n || abort) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos == FRAME - 1) begin
      if (cont) m_pos = 0;
      else m_act = 1'b0;
    end else begin
      m_pos++;
    end
    #1;
    cmp();
  endtask

  initial begin
    int done_at, rises, rg_cnt, dcount, blow;
    bit prev_l1, found;
    n_chk = 0; n_fail = 0;
    m_act = 0; m_pos = 0;
    rst_n = 0; start = 0; cont = 0; abort = 0;
    repeat (3) @(posedge clk);
    #1;
    cmp();
    rst_n = 1;
    repeat (50) step();

    // single frame
    start = 1;
    step();
    start = 0;
    done_at = -1; rises = 0; rg_cnt = 0;
    prev_l1 = phi_l1;
    for (int c = 2; c <= 560; c++) begin
      step();
      if (fdone && done_at < 0) done_at = c;
      if (c <= LINE && phi_l1 && !prev_l1) rises++;
      prev_l1 = phi_l1;
`ifdef CCD_PHASE_RG_EN
      if (phi_rg) rg_cnt++;
`endif
    end
    check("done_cycle", done_at, FRAME);
    check("l1_rises_line0", rises, NP);
`ifdef CCD_PHASE_RG_EN
    check("rg_pulses", rg_cnt, NP * NL);
`endif

    // continuous frames
    cont = 1;
    start = 1;
    step();
    start = 0;
    dcount = 0; blow = 0;
    for (int c = 0; c < 2 * FRAME + 10; c++) begin
      step();
      if (fdone) dcount++;
      if (!busy) blow++;
    end
    check("cont_done_cnt", dcount, 2);
    check("cont_busy_low", blow, 0);
    cont = 0;
    repeat (FRAME) step();

    // abort in line 3 pixel 7 with simultaneous start
    start = 1;
    step();
    start = 0;
    found = 0;
    for (int c = 0; c < 4000 && !found; c++) begin
      step();
      if (line == 3 && pix == 7 && en) found = 1;
    end
    check("abort_reached", int'(found), 1);
    abort = 1; start = 1;
    step();
    abort = 0; start = 0;
    check("abort_busy", int'(busy), 0);
    repeat (10) step();
    start = 1;
    step();
    start = 0;
    repeat (100) step();

    // asynchronous reset mid-frame
    rst_n = 0;
    #1;
    check("rst_phi_p", int'(phi_p), 0);
    check("rst_l1", int'(phi_l1), 1);
    check("rst_enable", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_line", int'(line), 0);
    m_act = 0;
    repeat (2) step();
    rst_n = 1;
    repeat (5) step();

    // random traffic
    for (int c = 0; c < 6000; c++) begin
      start = ($urandom % 40) == 0;
      abort = ($urandom % 1500) == 0;
      if (($urandom % 400) == 0) cont = ~cont;
      step();
    end
    start = 0; abort = 0; cont = 0;
    repeat (FRAME + 5) step();
    check("final_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
